// File: rtl/uart_tx.sv
// uart_tx: serial transmitter fed from a show-ahead TX FIFO.
// Frame: start bit, DATA_WIDTH data bits LSB-first, optional parity, one or two stop bits.
// Divisor, parity and stop configuration are captured when the word is popped.
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [DIV_WIDTH-1:0]  i_baud_div,
  input  logic                  i_par_en,
  input  logic                  i_par_odd,
  input  logic                  i_stop2,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [DATA_WIDTH-1:0] LAST_BIT = DATA_WIDTH'(DATA_WIDTH - 1);

  state_t                state_q,    state_d;
  logic [DATA_WIDTH-1:0] shift_q,    shift_d;
  logic [DATA_WIDTH-1:0] bit_idx_q,  bit_idx_d;
  logic [DIV_WIDTH-1:0]  cnt_q,      cnt_d;
  logic [DIV_WIDTH-1:0]  div_q,      div_d;
  logic                  par_en_q,   par_en_d;
  logic                  par_bit_q,  par_bit_d;
  logic                  stop2_q,    stop2_d;
  logic                  stop_idx_q, stop_idx_d;
  logic                  tx_q,       tx_d;
  logic                  busy_q,     busy_d;
  logic                  bit_end;

  // The current bit period finishes on the clock where the countdown reaches zero.
  assign bit_end = (cnt_q == '0);

  // A pop is only possible from IDLE, and is held off while reset is asserted.
  assign o_fifo_rd = (state_q == IDLE) && i_en && !i_fifo_empty && !i_rst;

  // Done marks the final clock of the final stop bit.
  assign o_done = (state_q == STOP) && bit_end && (stop_idx_q == stop2_q);

  assign o_tx   = tx_q;
  assign o_busy = busy_q;

  // Next-state logic: frame sequencing, bit timing, shifting, and registered line value.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_idx_d = stop_idx_q;

    case (state_q)
      IDLE: begin
        if (o_fifo_rd) begin
          shift_d    = i_fifo_data;
          div_d      = i_baud_div;
          cnt_d      = i_baud_div;
          par_en_d   = i_par_en;
          par_bit_d  = (^i_fifo_data) ^ i_par_odd;
          stop2_d    = i_stop2;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          state_d    = START;
        end
      end

      START: begin
        if (bit_end) begin
          cnt_d   = div_q;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_d   = div_q;
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            state_d    = par_en_q ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + DATA_WIDTH'(1);
          end
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end

      PARITY: begin
        if (bit_end) begin
          cnt_d      = div_q;
          stop_idx_d = 1'b0;
          state_d    = STOP;
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end

      STOP: begin
        if (bit_end) begin
          if (stop_idx_q == stop2_q) begin
            state_d = IDLE;
          end else begin
            stop_idx_d = 1'b1;
            cnt_d      = div_q;
          end
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // The line value is registered, so derive it from where the frame will be next clock.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_d;
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      cnt_q      <= '0;
      div_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter stage directly downstream of the TX FIFO.
- Pops one word whenever the FIFO is non-empty, then shifts it out on the serial line as: start bit, data LSB-first, optional parity bit, one or two stop bits.
- Bit timing comes from an internal divider counter.
- Frame configuration is latched at frame start.

Parameters:
- DATA_WIDTH, 8, data bits per frame; must equal the FIFO WIDTH.
- DIV_WIDTH, 16, width of the baud divisor input and the bit-period counter.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_en  input  1  transmitter enable; gates new frame starts only.
- i_baud_div  input  DIV_WIDTH  bit period = i_baud_div+1 clocks.
- i_par_en  input  1  1 = parity bit inserted after data.
- i_par_odd  input  1  parity sense: 0 = even, 1 = odd; ignored when i_par_en=0.
- i_stop2  input  1  0 = one stop bit, 1 = two stop bits.
- i_fifo_data  input  DATA_WIDTH  FIFO head word; show-ahead, valid whenever i_fifo_empty=0.
- i_fifo_empty  input  1  FIFO empty flag.
- o_fifo_rd  output  1  FIFO pop strobe, one cycle per word.
- o_tx  output  1  serial line; idle high.
- o_busy  output  1  high from START through the last STOP clock.
- o_done  output  1  one-cycle pulse on the last clock of the final stop bit.

Behaviour:
- Reset (asserted any time, including mid-frame):
  - takes effect immediately (async) and overrides everything else;
  - o_tx=1, o_busy=0, o_done=0, o_fifo_rd=0;
  - state=IDLE, counters and shift register cleared;
  - the partial frame is abandoned, and the FIFO word already popped is lost.
- States: IDLE, START, DATA, PARITY, STOP.
- o_fifo_rd:
  - combinational = (state==IDLE) & i_en & ~i_fifo_empty;
  - never asserted outside IDLE;
  - never asserted while i_fifo_empty=1.
- IDLE:
  - o_tx=1.
  - On a clock edge with o_fifo_rd=1:
    - latch i_fifo_data into the shift register;
    - latch i_baud_div, i_par_en, i_par_odd, i_stop2;
    - compute parity over the latched word: even -> XOR of bits, odd -> inverted XOR;
    - go to START.
  - o_tx is registered, so the start bit appears the clock after the pop cycle.
- Bit counter:
  - reloads to the latched divisor at each bit start;
  - decrements each clock;
  - the bit ends when it is 0.
  - Each bit is held exactly div+1 clocks; div=0 gives 1 clock per bit.
- START: o_tx=0 for one bit period, then go to DATA.
- DATA:
  - o_tx = shift-register LSB;
  - shift right at each bit end;
  - a DATA_WIDTH-bit index counts bits;
  - after DATA_WIDTH bits, go to PARITY if par_en, else to STOP.
- PARITY: o_tx = latched parity bit for one bit period, then go to STOP.
- STOP:
  - o_tx=1 for 1 or 2 bit periods according to latched stop2;
  - o_done=1 on the final clock of the final stop bit;
  - then go to IDLE.
- Frame length = (1 + DATA_WIDTH + par_en + 1 + stop2) × (div+1) clocks.
- Back-to-back frames:
  - after STOP, exactly one IDLE clock (line high) elapses before the next pop;
  - the gap between frames is therefore 1 clock beyond the stop bits.
- Configuration inputs are sampled only on the pop edge. Changes mid-frame do not affect the current frame.
- i_en deasserted mid-frame: the current frame completes normally, and no new pop follows.
- i_fifo_empty rising mid-frame: no effect on the current frame.
- o_busy = (state != IDLE), registered together with the state.

Test Plan:
- Reset, then hold i_fifo_empty=1, i_en=1 for 100 clocks -> o_tx=1, o_fifo_rd never asserted, o_busy=0.
- div=3, par_en=1, par_odd=0, stop2=0, FIFO holds 0xA5:
  - exactly one o_fifo_rd pulse;
  - o_tx sequence, 4 clocks per bit: 0,1,0,1,0,0,1,0,1,0(parity),1;
  - 44 clocks total;
  - o_done pulses on clock 44.
- Same frame with par_odd=1, stop2=1:
  - parity bit = 1;
  - two stop bits;
  - 48 clocks total.
- FIFO holds 0x00 and 0xFF, par_en=0, div=0:
  - two pops;
  - frames 0,00000000,1 and 0,11111111,1;
  - exactly one idle-high clock between the frames.
- Change i_baud_div 3 -> 7 and i_stop2 mid-frame:
  - current frame keeps 4-clock bits and its original stop count;
  - the next frame uses 8-clock bits.
- Assert i_rst during DATA bit 3:
  - o_tx=1 and o_busy=0 immediately (async);
  - after release with FIFO non-empty, a new pop occurs on the first IDLE cycle.
